div_16by8_unsigned: RTL and testbench



---
 rtl/div_pkg.sv | 15 +
 rtl/div_step_us.sv | 23 ++
 rtl/div_16by8_unsigned.sv | 133 +++++++++++++
 tb/tb_div_16by8_unsigned.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants and state encoding for the 16-by-8 unsigned divider.
// Imported by the divider top level and its step cell.
package div_pkg;

    localparam int N     = 8;
    localparam int DW    = 16;
    localparam int STEPS = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step_us.sv
// One restoring division step: shift in a dividend bit, trial-subtract
// the divisor and keep the difference only when it is non-negative.
module div_step_us #(
    parameter int N = 8
) (
    input  logic [N:0]   r_in,
    input  logic         bit_in,
    input  logic [N-1:0] d,
    output logic [N:0]   r_out,
    output logic         q
);

    logic [N+1:0] wide;
    logic [N+1:0] diff;

    always_comb begin
        wide  = {r_in, bit_in};
        diff  = wide - {2'b00, d};
        q     = ~diff[N+1];
        r_out = q ? diff[N:0] : wide[N:0];
    end

endmodule

// File: rtl/div_16by8_unsigned.sv
// Sequential radix-2 restoring divider, 2N-bit dividend by N-bit divisor.
// Overflow and divide-by-zero resolve at the load edge without iterating.
module div_16by8_unsigned #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic [2*N-1:0] a,
    input  logic [N-1:0]   b,
    output logic [N-1:0]   quot,
    output logic [N-1:0]   rem,
    output logic           busy,
    output logic           done,
    output logic           ovf,
    output logic           dbz
);

    import div_pkg::*;

    div_state_t   state_q, state_d;
    logic [N:0]   r_q, r_d;
    logic [N-1:0] sh_q, sh_d;
    logic [N-1:0] b_q, b_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [N-1:0] quot_d, rem_d;
    logic         busy_d, done_d, ovf_d, dbz_d;

    logic [N:0]   r_step;
    logic         q_step;

    div_step_us #(.N(N)) u_step (
        .r_in   (r_q),
        .bit_in (sh_q[N-1]),
        .d      (b_q),
        .r_out  (r_step),
        .q      (q_step)
    );

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        sh_d    = sh_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        quot_d  = quot;
        rem_d   = rem;
        busy_d  = busy;
        done_d  = done;
        ovf_d   = ovf;
        dbz_d   = dbz;

        if (load) begin
            b_d    = b;
            sh_d   = a[N-1:0];
            r_d    = {1'b0, a[2*N-1:N]};
            cnt_d  = '0;
            ovf_d  = 1'b0;
            dbz_d  = 1'b0;
            unique case (1'b1)
                (b == '0): begin
                    dbz_d   = 1'b1;
                    quot_d  = '1;
                    rem_d   = a[N-1:0];
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
                (b != '0 && a[2*N-1:N] >= b): begin
                    ovf_d   = 1'b1;
                    quot_d  = '1;
                    rem_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
                default: begin
                    quot_d  = '0;
                    rem_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    state_d = CALC;
                end
            endcase
        end else begin
            unique case (state_q)
                CALC: begin
                    r_d    = r_step;
                    sh_d   = {sh_q[N-2:0], 1'b0};
                    quot_d = {quot[N-2:0], q_step};
                    cnt_d  = cnt_q + 4'd1;
                    // Last of the STEPS iterations lands the final result.
                    if (cnt_q == 4'(STEPS - 1)) begin
                        rem_d   = r_step[N-1:0];
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            r_q     <= '0;
            sh_q    <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            quot    <= '0;
            rem     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ovf     <= 1'b0;
            dbz     <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            sh_q    <= sh_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            quot    <= quot_d;
            rem     <= rem_d;
            busy    <= busy_d;
            done    <= done_d;
            ovf     <= ovf_d;
            dbz     <= dbz_d;
        end
    end

endmodule

// File: tb/tb_div_16by8_unsigned.sv
// Directed and random checks of the sequential 16-by-8 unsigned divider.
// Outputs are sampled 1 time unit after each rising edge.
module tb_div_16by8_unsigned;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] a = '0;
    logic [7:0]  b = '0;
    logic [7:0]  quot, rem;
    logic        busy, done, ovf, dbz;

    int n_cmp = 0;
    int n_err = 0;

    div_16by8_unsigned dut (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .a    (a),
        .b    (b),
        .quot (quot),
        .rem  (rem),
        .busy (busy),
        .done (done),
        .ovf  (ovf),
        .dbz  (dbz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [15:0] av, input logic [7:0] bv);
        @(negedge clk);
        a    = av;
        b    = bv;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic chk_all(input string tag, input logic [7:0] q,
                           input logic [7:0] r, input logic bz,
                           input logic dn, input logic ov, input logic dz);
        chk({tag, ".quot"}, 16'(quot), 16'(q));
        chk({tag, ".rem"},  16'(rem),  16'(r));
        chk({tag, ".busy"}, 16'(busy), 16'(bz));
        chk({tag, ".done"}, 16'(done), 16'(dn));
        chk({tag, ".ovf"},  16'(ovf),  16'(ov));
        chk({tag, ".dbz"},  16'(dbz),  16'(dz));
    endtask

    task automatic run_iter(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            chk({tag, ".busy_iter"}, 16'(busy), 16'd1);
            chk({tag, ".done_iter"}, 16'(done), 16'd0);
            tick();
        end
    endtask

    initial begin
        logic [15:0] ra;
        logic [7:0]  rb, eq, er, q0, r0;
        logic        eo;
        int          cyc;

        // Reset state
        tick();
        tick();
        chk_all("reset", 8'd0, 8'd0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        // 45 / 9: busy on edges k..k+7, done at k+8
        start(16'd45, 8'd9);
        run_iter("div45", 7);
        chk({"div45", ".busy_k7"}, 16'(busy), 16'd1);
        tick();
        chk_all("div45", 8'd5, 8'd0, 0, 1, 0, 0);

        // Result held while a/b wander in DONE
        a = 16'hFFFF;
        b = 8'd1;
        tick();
        tick();
        chk_all("hold", 8'd5, 8'd0, 0, 1, 0, 0);

        start(16'd58750, 8'd230);
        run_iter("div58750", 8);
        chk_all("div58750", 8'd255, 8'd100, 0, 1, 0, 0);

        start(16'd15000, 8'd100);
        run_iter("div15000", 8);
        chk_all("div15000", 8'd150, 8'd0, 0, 1, 0, 0);

        // Overflow and divide-by-zero resolve at the load edge
        start(16'd60000, 8'd200);
        chk_all("ovf", 8'hFF, 8'h00, 0, 1, 1, 0);
        start(16'h1234, 8'd0);
        chk_all("dbz", 8'hFF, 8'h34, 0, 1, 0, 1);
        tick();
        chk_all("dbz_hold", 8'hFF, 8'h34, 0, 1, 0, 1);

        // Restart at k+3 with new operands
        start(16'd1000, 8'd7);
        run_iter("abort", 2);
        @(negedge clk);
        a    = 16'd200;
        b    = 8'd13;
        load = 1'b1;
        tick();
        load = 1'b0;
        run_iter("restart", 8);
        chk_all("restart", 8'd15, 8'd5, 0, 1, 0, 0);

        // Reset mid-operation at k+4
        start(16'd500, 8'd3);
        run_iter("pre_rst", 3);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk_all("mid_rst", 8'd0, 8'd0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk_all("post_rst", 8'd0, 8'd0, 0, 0, 0, 0);
        start(16'd500, 8'd3);
        run_iter("div500", 8);
        chk_all("div500", 8'd166, 8'd2, 0, 1, 0, 0);

        // Random sweep against integer division
        for (int t = 0; t < 2000; t++) begin
            ra = 16'($urandom);
            rb = 8'($urandom_range(1, 255));
            eo = (ra[15:8] >= rb);
            eq = eo ? 8'hFF : 8'(ra / 16'(rb));
            er = eo ? 8'h00 : 8'(ra % 16'(rb));
            start(ra, rb);
            cyc = 0;
            while (!done && cyc < 12) begin
                tick();
                cyc++;
            end
            chk("rnd.done", 16'(done), 16'd1);
            chk("rnd.quot", 16'(quot), 16'(eq));
            chk("rnd.rem", 16'(rem), 16'(er));
            chk("rnd.ovf", 16'(ovf), 16'(eo));
            q0 = quot;
            r0 = rem;
            a  = 16'($urandom);
            tick();
            chk("rnd.stable_q", 16'(quot), 16'(q0));
            chk("rnd.stable_r", 16'(rem), 16'(r0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
